// File: rtl/snes_load_pkg.sv
// Shared types for the ROM download path: loader states, region default and FIFO entry layout.
package snes_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } load_state_t;

  localparam logic [3:0] REGION_NIBBLE_DEFAULT = 4'h1;

  // One buffered bridge write: byte address of the word and its big-endian data.
  typedef struct packed {
    logic [24:0] addr;
    logic [31:0] data;
  } fifo_entry_t;

  // Turns a big-endian byte pair into a little-endian halfword.
  function automatic logic [15:0] swap_half(input logic [15:0] be);
    return {be[7:0], be[15:8]};
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO of bridge words with a flush that still accepts a same-cycle push.
module word_fifo
  import snes_load_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fifo_entry_t                  push_data,
  input  logic                         pop,
  output fifo_entry_t                  head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fifo_entry_t    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_slot;
  logic           do_push;
  logic           do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A flush empties the queue first, so a push in the same cycle lands in slot 0 and never overflows.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    wr_slot = wr_ptr;
    if (flush) begin
      do_push = push;
      wr_slot = '0;
    end else begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
    end
  end

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_slot] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_download_stream.sv
// Turns 32-bit big-endian bridge dataslot writes into the 16-bit little-endian ioctl stream.
module rom_download_stream
  import snes_load_pkg::*;
#(
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [3:0] REGION_NIBBLE = REGION_NIBBLE_DEFAULT
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  input  logic        dataslot_start,
  input  logic        dataslot_done,
  input  logic [31:0] rom_file_size,
  input  logic        ioctl_ready,
  output logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_data,
  output logic        ioctl_wr,
  output logic        downloading,
  output logic        overflow,
  output logic [23:0] halfword_count
);

  load_state_t  state;
  load_state_t  state_next;
  logic         half_lo;
  fifo_entry_t  fifo_head;
  fifo_entry_t  fifo_in;
  logic         fifo_full;
  logic         fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic         fifo_push;
  logic         fifo_pop;
  logic         slot_free;
  logic         produce;
  logic         take_wr;
  logic         drop_wr;
  logic [24:0]  cand_addr;
  logic [15:0]  cand_data;
  logic [31:0]  byte_limit;
  logic         in_range;
  logic         unused_bits;

  assign unused_bits = ^{bridge_addr[27:25], fifo_count};
  assign fifo_in     = '{addr: bridge_addr[24:0], data: bridge_wr_data};
  assign downloading = (state != ST_IDLE);

  word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_74a),
    .reset     (reset),
    .flush     (dataslot_start),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The head entry stays in the FIFO until its LO half is issued, so the FIFO always holds every unfinished word.
  always_comb begin
    slot_free  = !ioctl_wr || ioctl_ready;
    produce    = slot_free && !fifo_empty && !dataslot_start;
    fifo_pop   = produce && half_lo;
    take_wr    = bridge_wr && (bridge_addr[31:28] == REGION_NIBBLE)
                 && ((state != ST_IDLE) || dataslot_start);
    fifo_push  = take_wr && (dataslot_start || !fifo_full || fifo_pop);
    drop_wr    = take_wr && !dataslot_start && fifo_full && !fifo_pop;
    cand_addr  = half_lo ? (fifo_head.addr + 25'd2) : fifo_head.addr;
    cand_data  = half_lo ? swap_half(fifo_head.data[15:0]) : swap_half(fifo_head.data[31:16]);
    byte_limit = (rom_file_size + 32'd1) & ~32'd1;
    in_range   = ({7'd0, cand_addr} < byte_limit);
  end

  // Loader state register.
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start pulse restarts from any state; drain ends once nothing is buffered, pending or presented.
  always_comb begin
    state_next = state;
    if (dataslot_start) begin
      state_next = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_IDLE;
        ST_LOAD:  if (dataslot_done) state_next = ST_DRAIN;
        ST_DRAIN: if (fifo_empty && !half_lo && !ioctl_wr && !fifo_push) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output register: issues HI then LO per entry, skips halfwords past the file end, holds while not ready.
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_data     <= '0;
      half_lo        <= 1'b0;
      overflow       <= 1'b0;
      halfword_count <= '0;
    end else if (dataslot_start) begin
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_data     <= '0;
      half_lo        <= 1'b0;
      overflow       <= 1'b0;
      halfword_count <= '0;
    end else begin
      if (drop_wr) begin
        overflow <= 1'b1;
      end
      if (ioctl_wr && ioctl_ready && (halfword_count != '1)) begin
        halfword_count <= halfword_count + 24'd1;
      end
      if (produce) begin
        half_lo  <= !half_lo;
        ioctl_wr <= in_range;
        if (in_range) begin
          ioctl_addr <= cand_addr;
          ioctl_data <= cand_data;
        end
      end else if (slot_free) begin
        ioctl_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_download_stream.sv
// Scoreboard bench for rom_download_stream: expected halfwords queued at write time, checked on acceptance.
module tb_rom_download_stream;

  logic        clk_74a = 1'b0;
  logic        reset;
  logic        bridge_wr;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        dataslot_start;
  logic        dataslot_done;
  logic [31:0] rom_file_size;
  logic        ioctl_ready;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_data;
  logic        ioctl_wr;
  logic        downloading;
  logic        overflow;
  logic [23:0] halfword_count;

  int          compared = 0;
  int          mismatched = 0;
  int          accepted = 0;
  logic [40:0] sb [$];
  logic [31:0] file_size = 32'd0;
  bit          toggle_mode = 1'b0;
  bit          held_prev = 1'b0;
  logic [41:0] held_val = '0;

  rom_download_stream dut (
    .clk_74a        (clk_74a),
    .reset          (reset),
    .bridge_wr      (bridge_wr),
    .bridge_addr    (bridge_addr),
    .bridge_wr_data (bridge_wr_data),
    .dataslot_start (dataslot_start),
    .dataslot_done  (dataslot_done),
    .rom_file_size  (rom_file_size),
    .ioctl_ready    (ioctl_ready),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .downloading    (downloading),
    .overflow       (overflow),
    .halfword_count (halfword_count)
  );

  always #5 clk_74a = ~clk_74a;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: little-endian halfwords of one bridge word that fall inside the rounded-up file size.
  function automatic void expectWord(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] limit;
    logic [24:0] a;
    limit = (file_size + 32'd1) & ~32'd1;
    a = addr[24:0];
    if ({7'd0, a} < limit) sb.push_back({a, data[23:16], data[31:24]});
    a = a + 25'd2;
    if ({7'd0, a} < limit) sb.push_back({a, data[7:0], data[15:8]});
  endfunction

  task automatic stepCycle();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input bit taken);
    bridge_wr      = 1'b1;
    bridge_addr    = addr;
    bridge_wr_data = data;
    if (taken) expectWord(addr, data);
    stepCycle();
    bridge_wr = 1'b0;
  endtask

  task automatic startDownload(input logic [31:0] size);
    file_size      = size;
    rom_file_size  = size;
    dataslot_start = 1'b1;
    stepCycle();
    dataslot_start = 1'b0;
  endtask

  task automatic finishDownload();
    dataslot_done = 1'b1;
    stepCycle();
    dataslot_done = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || downloading) && n < budget) begin
      @(negedge clk_74a);
      n++;
    end
    checkOutput("drain", {(sb.size() == 0), downloading}, 2'b10);
    stepCycle();
  endtask

  // Acceptance monitor: every accepted halfword must be the next scoreboard entry; held words must not change.
  always @(negedge clk_74a) begin
    logic [40:0] exp_hw;
    if (!reset) begin
      if (held_prev) checkOutput("hold", {ioctl_wr, ioctl_addr, ioctl_data}, held_val);
      if (ioctl_wr && ioctl_ready) begin
        exp_hw = (sb.size() != 0) ? sb.pop_front() : '1;
        checkOutput("wr_halfword", {ioctl_addr, ioctl_data}, exp_hw);
        checkOutput("dl_during", downloading, 1'b1);
        accepted++;
      end
      held_prev = ioctl_wr && !ioctl_ready && !dataslot_start;
      held_val  = {ioctl_wr, ioctl_addr, ioctl_data};
    end else begin
      held_prev = 1'b0;
    end
  end

  // Ready toggler for the back-pressure test.
  always @(posedge clk_74a) begin
    if (toggle_mode) begin
      #1;
      ioctl_ready = ~ioctl_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n;
    reset = 1'b1; bridge_wr = 1'b0; bridge_addr = '0; bridge_wr_data = '0;
    dataslot_start = 1'b0; dataslot_done = 1'b0; rom_file_size = '0; ioctl_ready = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset_out", {ioctl_wr, ioctl_addr, ioctl_data}, 0);
    checkOutput("reset_status", {downloading, overflow, halfword_count}, 0);
    reset = 1'b0;
    stepCycle();

    $display("[TB] basic stream, size 8");
    startDownload(32'd8);
    applyStimulus(32'h1000_0000, 32'h1122_3344, 1'b1);
    checkOutput("latency_n1", ioctl_wr, 1'b0);
    applyStimulus(32'h1000_0004, 32'h5566_7788, 1'b1);
    checkOutput("latency_n2", {ioctl_wr, ioctl_addr, ioctl_data}, {1'b1, 25'd0, 16'h2211});
    finishDownload();
    checkOutput("second_hw", {ioctl_wr, ioctl_addr, ioctl_data}, {1'b1, 25'd2, 16'h4433});
    waitDrain(50);
    checkOutput("count_basic", halfword_count, 24'd4);

    $display("[TB] tail trim, size 5");
    startDownload(32'd5);
    applyStimulus(32'h1000_0000, 32'hAABB_CCDD, 1'b1);
    applyStimulus(32'h1000_0004, 32'hEEFF_0011, 1'b1);
    finishDownload();
    waitDrain(50);
    checkOutput("count_trim", halfword_count, 24'd3);

    $display("[TB] overflow burst with ready low");
    ioctl_ready = 1'b0;
    startDownload(32'd4096);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h1000_0100 + 32'(4 * i), 32'hA1B2_C3D4 ^ (32'(i) * 32'h0101_0101), i < 4);
      if (i == 3) checkOutput("ovf_before", overflow, 1'b0);
      if (i == 4) checkOutput("ovf_after5", overflow, 1'b1);
    end
    finishDownload();
    repeat (3) stepCycle();
    ioctl_ready = 1'b1;
    waitDrain(100);
    checkOutput("ovf_sticky", overflow, 1'b1);
    checkOutput("count_ovf", halfword_count, 24'd8);

    $display("[TB] ready toggling");
    startDownload(32'd4096);
    toggle_mode = 1'b1;
    applyStimulus(32'h1000_0040, 32'h0102_0304, 1'b1);
    applyStimulus(32'h1000_0044, 32'h0506_0708, 1'b1);
    finishDownload();
    waitDrain(100);
    toggle_mode = 1'b0;
    stepCycle();
    stepCycle();
    ioctl_ready = 1'b1;
    checkOutput("count_toggle", halfword_count, 24'd4);

    $display("[TB] ignored writes");
    applyStimulus(32'h1000_0000, 32'hDEAD_BEEF, 1'b0);
    repeat (4) stepCycle();
    checkOutput("idle_ignored", {ioctl_wr, downloading}, 2'b00);
    startDownload(32'd4096);
    applyStimulus(32'h2000_0000, 32'hCAFE_F00D, 1'b0);
    repeat (4) stepCycle();
    checkOutput("region_ignored", ioctl_wr, 1'b0);
    finishDownload();
    waitDrain(50);
    checkOutput("count_ignored", halfword_count, 24'd0);

    $display("[TB] reset mid-download");
    ioctl_ready = 1'b0;
    startDownload(32'd4096);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h1000_0080 + 32'(4 * i), 32'h1020_3040 + 32'(i), 1'b1);
    end
    base = accepted;
    n = 0;
    ioctl_ready = 1'b1;
    while (accepted < base + 3 && n < 100) begin
      @(negedge clk_74a);
      n++;
    end
    checkOutput("reach_three", accepted - base, 3);
    @(posedge clk_74a);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset_out", {ioctl_wr, ioctl_addr, ioctl_data}, 0);
    checkOutput("midreset_status", {downloading, overflow, halfword_count}, 0);
    sb.delete();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    startDownload(32'd4096);
    applyStimulus(32'h1000_0200, 32'h0BAD_CAFE, 1'b1);
    finishDownload();
    waitDrain(50);
    checkOutput("count_fresh", halfword_count, 24'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_download_stream.md
# rom_download_stream

Converts APF bridge 32-bit dataslot writes on `clk_74a` into the 16-bit little-endian word stream (`ioctl_addr`/`ioctl_data`/`ioctl_wr`/`downloading`) consumed by the ROM header parser and the SDRAM ROM writer. It sits directly upstream of both. It buffers bursty bridge writes in a small FIFO and byte-swaps the big-endian bridge data. It trims the tail beyond the file size and generates the `downloading` window the parser uses to finalise its ROM-type decision.

## Interface
- `FIFO_DEPTH`, 4: 32-bit entries buffered; power of two, ≥2.
- `REGION_NIBBLE`, 4'h1: value of `bridge_addr[31:28]` that selects the ROM dataslot.

Ports:
- `clk_74a`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `bridge_wr`  in  1  bridge write strobe, one cycle per 32-bit word.
- `bridge_addr`  in  32  byte address of the write; only writes with `[31:28]==REGION_NIBBLE` are taken.
- `bridge_wr_data`  in  32  big-endian data; `[31:24]` is the byte at `bridge_addr+0`.
- `dataslot_start`  in  1  one-cycle pulse: download begins.
- `dataslot_done`  in  1  one-cycle pulse: bridge has sent the last word.
- `rom_file_size`  in  32  file size in bytes, valid from `dataslot_start`.
- `ioctl_ready`  in  1  downstream accepts the current word this cycle.
- `ioctl_addr`  out  25  byte address of the halfword (always even).
- `ioctl_data`  out  16  `[7:0]`=byte at even address, `[15:8]`=byte at address+1.
- `ioctl_wr`  out  1  word valid; held with stable addr/data until `ioctl_ready`.
- `downloading`  out  1  download window.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `halfword_count`  out  24  halfwords transferred this download.

## Operation
- All outputs reset to 0.
- States: IDLE → LOAD on `dataslot_start`. LOAD → DRAIN on `dataslot_done`. DRAIN → IDLE when the FIFO is empty, the half-select is at HI, and `ioctl_wr`=0.
- `downloading`=1 in LOAD and DRAIN.
- `dataslot_start` in any state:
  - flushes the FIFO and drops the output word;
  - clears `overflow` and `halfword_count`;
  - enters LOAD.
- Writes are accepted only in LOAD or DRAIN, with a region match. Writes in IDLE or to other regions are ignored.
- A write while the FIFO is full is dropped and sets `overflow`. The FIFO contents are unchanged.
- Each FIFO entry `{addr[24:0], data}` yields two halfwords, HI first then LO:
  - HI: `ioctl_addr=addr`, `ioctl_data={data[23:16],data[31:24]}`.
  - LO: `ioctl_addr=addr+2` (25-bit wrap), `ioctl_data={data[7:0],data[15:8]}`.
- Tail trim:
  - A halfword with `ioctl_addr >= ((rom_file_size+1) & ~1)` is discarded without asserting `ioctl_wr`, consuming one cycle.
  - The compare is 32-bit, with `ioctl_addr` zero-extended.
- `halfword_count` increments on each `ioctl_wr && ioctl_ready` and saturates at all-ones.

## Timing
- A bridge write in cycle n is in the FIFO at n+1. `ioctl_wr` rises at n+2 if the pipeline was empty.
- Throughput: one halfword per cycle while `ioctl_ready`=1, i.e. one bridge word per 2 cycles. Faster bridge bursts are absorbed by the FIFO.
- A new word is presented in the cycle after acceptance; there is no bubble between HI and LO or between entries.
- `downloading` falls in the cycle after the final accepted halfword (or the final discarded halfword).
- Simultaneous events in one cycle:
  - `dataslot_start` + `bridge_wr`: the flush happens first, then the write is accepted into the empty FIFO.
  - `dataslot_done` + `bridge_wr`: the write is accepted, then DRAIN.
  - FIFO push + pop: both occur; the count is unchanged, and a full FIFO does not overflow.
- `ioctl_ready` low: addr, data and `ioctl_wr` are held indefinitely.
- Reset mid-download: immediate clear; `downloading` drops asynchronously.

## Structure
- Package `snes_load_pkg`: the state enum (IDLE/LOAD/DRAIN), `REGION_NIBBLE` default, and the FIFO entry struct (addr 25, data 32).
- Sub-module `word_fifo`: a synchronous FIFO with async reset, a flush input, and full/empty/count outputs. The top level holds the FSM, the half-select and the output register.

## Test plan
- Size 8 at 0x1000_0000: write 0x11223344, then 0x55667788 with ready=1. Required output, at consecutive cycles starting n+2: (0,0x2211), (2,0x4433), (4,0x6655), (6,0x8877). `downloading` falls after the last word. Count=4.
- File size 5, data 0xAABBCCDD then 0xEEFF0011. Required outputs: addr 0, 2 and 4 only (0x4 → 0xFFEE). Addr 6 is discarded. Count=3.
- A burst of 6 back-to-back writes with ready=0 and depth 4. Required: `overflow`=1 after the 5th write, 4 entries retained. On ready=1, 8 halfwords in order.
- `ioctl_ready` toggling 1/0 every cycle. Required: each word held until accepted, no duplicates, and `downloading` stays high until the final acceptance.
- A write to 0x2000_0000, and a write in IDLE. Required: ignored, with no `ioctl_wr`.
- Reset asserted after 3 halfwords of 8. Required: all outputs 0 immediately. A new start plus 1 write then yields a fresh stream with count=2.
